// File: rtl/soc_boot_ctrl.sv
// soc_boot_ctrl: UART-driven boot/debug controller.
// Parses a byte command stream from the UART receiver, holds the SoC core in
// reset until told to release it, performs word reads/writes on the SoC
// memory port and returns responses through the UART transmitter.
//
// Commands (multi-byte fields little-endian):
//   'W' A0..A3 D0..D3 [C]  write word   -> ACK (0x06)
//   'R' A0..A3             read word    -> 4 data bytes, LSB first
//   'G'                    release core -> ACK
//   'H'                    hold core    -> ACK
//   unknown opcode / inter-byte timeout -> NAK (0x15)
// mem_addr = A[ADDR_W+1:2].
//
// Optional build macro: BOOT_CHECKSUM_EN -- 'W' carries a 10th byte C that
// must equal the XOR of A0..A3,D0..D3; on mismatch no access is made and NAK
// is returned.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_valid, rx_data     received byte strobe (no backpressure)
//   tx_valid, tx_data     response byte, held until tx_ready
//   tx_ready              transmitter accepts tx_data this cycle
//   mem_req, mem_we       memory request / write enable
//   mem_addr, mem_wdata   word address / write data
//   mem_rdata, mem_ack    read data / one-cycle completion strobe
//   core_reset            active-high reset to the SoC core
//   overrun               sticky: byte arrived while not accepting
module soc_boot_ctrl #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              core_reset,
  output logic              overrun
);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_G = 8'h47;
  localparam logic [7:0] OP_H = 8'h48;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  localparam int unsigned    TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef BOOT_CHECKSUM_EN
    GET_CSUM,
`endif
    MEM,
    RESP,
    SEND_RD
  } state_t;

  state_t          state, state_n;
  logic [1:0]      byte_cnt, byte_cnt_n;
  logic            is_wr, is_wr_n;
  logic [31:0]     addr_sh, addr_sh_n;
  logic [31:0]     data_sh, data_sh_n;
  logic [31:0]     rd_data, rd_data_n;
  logic [1:0]      rd_idx, rd_idx_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic            tmo_hit;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]      csum, csum_n;
`endif
  logic              tx_valid_n;
  logic [7:0]        tx_data_n;
  logic              mem_req_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;
  logic              core_reset_n, overrun_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      is_wr      <= 1'b0;
      addr_sh    <= '0;
      data_sh    <= '0;
      rd_data    <= '0;
      rd_idx     <= '0;
      tmo        <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_reset <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      is_wr      <= is_wr_n;
      addr_sh    <= addr_sh_n;
      data_sh    <= data_sh_n;
      rd_data    <= rd_data_n;
      rd_idx     <= rd_idx_n;
      tmo        <= tmo_n;
`ifdef BOOT_CHECKSUM_EN
      csum       <= csum_n;
`endif
      tx_valid   <= tx_valid_n;
      tx_data    <= tx_data_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      core_reset <= core_reset_n;
      overrun    <= overrun_n;
    end
  end

  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    is_wr_n      = is_wr;
    addr_sh_n    = addr_sh;
    data_sh_n    = data_sh;
    rd_data_n    = rd_data;
    rd_idx_n     = rd_idx;
    tmo_n        = '0;
    tmo_hit      = (tmo == TMO_LAST);
`ifdef BOOT_CHECKSUM_EN
    csum_n       = csum;
`endif
    tx_valid_n   = tx_valid;
    tx_data_n    = tx_data;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    core_reset_n = core_reset;
    overrun_n    = overrun;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          byte_cnt_n = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_n     = '0;
`endif
          case (rx_data)
            OP_W: begin is_wr_n = 1'b1; state_n = GET_ADDR; end
            OP_R: begin is_wr_n = 1'b0; state_n = GET_ADDR; end
            OP_G: begin
              core_reset_n = 1'b0;
              tx_valid_n   = 1'b1;
              tx_data_n    = ACK;
              state_n      = RESP;
            end
            OP_H: begin
              core_reset_n = 1'b1;
              tx_valid_n   = 1'b1;
              tx_data_n    = ACK;
              state_n      = RESP;
            end
            default: begin
              tx_valid_n = 1'b1;
              tx_data_n  = NAK;
              state_n    = RESP;
            end
          endcase
        end
      end

      GET_ADDR: begin
        // A byte on the timeout cycle is still taken, so rx_valid is tested first.
        if (rx_valid) begin
          addr_sh_n  = {rx_data, addr_sh[31:8]};
          byte_cnt_n = byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_n     = csum ^ rx_data;
`endif
          if (byte_cnt == 2'd3) begin
            if (is_wr) begin
              state_n = GET_DATA;
            end else begin
              state_n    = MEM;
              mem_req_n  = 1'b1;
              mem_we_n   = 1'b0;
              mem_addr_n = addr_sh_n[ADDR_W+1:2];
            end
          end
        end else if (tmo_hit) begin
          tx_valid_n = 1'b1;
          tx_data_n  = NAK;
          state_n    = RESP;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end

      GET_DATA: begin
        if (rx_valid) begin
          data_sh_n  = {rx_data, data_sh[31:8]};
          byte_cnt_n = byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_n     = csum ^ rx_data;
          if (byte_cnt == 2'd3) state_n = GET_CSUM;
`else
          if (byte_cnt == 2'd3) begin
            state_n     = MEM;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_addr_n  = addr_sh[ADDR_W+1:2];
            mem_wdata_n = data_sh_n;
          end
`endif
        end else if (tmo_hit) begin
          tx_valid_n = 1'b1;
          tx_data_n  = NAK;
          state_n    = RESP;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end

`ifdef BOOT_CHECKSUM_EN
      GET_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            state_n     = MEM;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_addr_n  = addr_sh[ADDR_W+1:2];
            mem_wdata_n = data_sh;
          end else begin
            tx_valid_n = 1'b1;
            tx_data_n  = NAK;
            state_n    = RESP;
          end
        end else if (tmo_hit) begin
          tx_valid_n = 1'b1;
          tx_data_n  = NAK;
          state_n    = RESP;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
`endif

      MEM: begin
        if (rx_valid) overrun_n = 1'b1;
        if (mem_ack) begin
          mem_req_n  = 1'b0;
          tx_valid_n = 1'b1;
          if (is_wr) begin
            tx_data_n = ACK;
            state_n   = RESP;
          end else begin
            rd_data_n = mem_rdata;
            tx_data_n = mem_rdata[7:0];
            rd_idx_n  = '0;
            state_n   = SEND_RD;
          end
        end
      end

      RESP: begin
        if (rx_valid) overrun_n = 1'b1;
        if (tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end

      SEND_RD: begin
        if (rx_valid) overrun_n = 1'b1;
        // rd_data shifts right so the byte on tx_data is always rd_data[7:0].
        if (tx_ready) begin
          if (rd_idx == 2'd3) begin
            tx_valid_n = 1'b0;
            state_n    = IDLE;
          end else begin
            rd_idx_n  = rd_idx + 2'd1;
            rd_data_n = {8'h00, rd_data[31:8]};
            tx_data_n = rd_data[15:8];
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// tb_soc_boot_ctrl: directed bench for soc_boot_ctrl with a command-level
// reference model (expected memory requests, expected tx bytes, expected
// core_reset/overrun) and a per-cycle compare process.
// Build with BOOT_CHECKSUM_EN defined to exercise the checksummed write.
module tb_soc_boot_ctrl;
  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b1;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          core_reset, overrun;

  always #5 clk = ~clk;

  soc_boot_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .core_reset(core_reset), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } mreq_t;

  logic [7:0]  exp_tx[$];
  mreq_t       exp_mem[$];
  logic [7:0]  cmd[$];
  logic [31:0] mdl_mem [0:(1<<AW)-1];
  logic [31:0] ram     [0:(1<<AW)-1];
  logic        exp_core = 1'b1;
  logic        exp_ovr  = 1'b0;
  int          ack_delay = 3;

  function automatic int cmd_len(input logic [7:0] op);
`ifdef BOOT_CHECKSUM_EN
    return (op == 8'h57) ? 10 : 5;
`else
    return (op == 8'h57) ? 9 : 5;
`endif
  endfunction

  function automatic void mdl_exec();
    logic [31:0]   a, d, w;
    logic [AW-1:0] wa;
    logic [7:0]    x;
    logic          ok;
    mreq_t         m;
    a  = {cmd[4], cmd[3], cmd[2], cmd[1]};
    wa = AW'(a >> 2);
    if (cmd[0] == 8'h52) begin
      m.we = 1'b0; m.addr = wa; m.wdata = '0;
      exp_mem.push_back(m);
      w = mdl_mem[wa];
      for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    end else begin
      d  = {cmd[8], cmd[7], cmd[6], cmd[5]};
      ok = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      x = '0;
      for (int i = 1; i <= 8; i++) x = x ^ cmd[i];
      ok = (cmd[9] == x);
`else
      x = '0;
`endif
      if (ok) begin
        m.we = 1'b1; m.addr = wa; m.wdata = d;
        exp_mem.push_back(m);
        mdl_mem[wa] = d;
        exp_tx.push_back(8'h06);
      end else begin
        exp_tx.push_back(8'h15);
      end
    end
    cmd.delete();
  endfunction

  function automatic void mdl_byte(input logic [7:0] b);
    if (cmd.size() == 0) begin
      case (b)
        8'h47: begin exp_core = 1'b0; exp_tx.push_back(8'h06); end
        8'h48: begin exp_core = 1'b1; exp_tx.push_back(8'h06); end
        8'h57, 8'h52: cmd.push_back(b);
        default: exp_tx.push_back(8'h15);
      endcase
    end else begin
      cmd.push_back(b);
      if (cmd.size() == cmd_len(cmd[0])) mdl_exec();
    end
  endfunction

  function automatic void mdl_timeout();
    cmd.delete();
    exp_tx.push_back(8'h15);
  endfunction

  function automatic void mdl_reset();
    cmd.delete();
    exp_tx.delete();
    exp_mem.delete();
    exp_core = 1'b1;
    exp_ovr  = 1'b0;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    logic [AW-1:0] a;
    int k;
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; mdl_mem[i] = '0; end
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        k = 0;
        while (k < ack_delay && rst_n) begin @(negedge clk); k++; end
        if (rst_n && mem_req) begin
          a = mem_addr;
          mem_rdata = ram[a];
          if (mem_we) ram[a] = mem_wdata;
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
          mem_rdata = '0;
          if (rst_n) begin
            check("ack_mem_req_drop", {63'd0, mem_req}, 64'd0);
            check("ack_to_tx_latency", {63'd0, tx_valid}, 64'd1);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       prev_txv = 1'b0, prev_rdy = 1'b0, prev_mreq = 1'b0;
  logic [7:0] prev_txd = '0;
  mreq_t      held, e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_txv = 1'b0; prev_rdy = 1'b0; prev_mreq = 1'b0;
    end else begin
      check("core_reset", {63'd0, core_reset}, {63'd0, exp_core});
      check("overrun", {63'd0, overrun}, {63'd0, exp_ovr});
      if (mem_req && !prev_mreq) begin
        if (exp_mem.size() == 0) begin
          check("mem_req_unexpected", {63'd0, mem_req}, 64'd0);
        end else begin
          e = exp_mem.pop_front();
          check("mem_we", {63'd0, mem_we}, {63'd0, e.we});
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
        held = {mem_we, mem_addr, mem_wdata};
      end else if (mem_req) begin
        check("mem_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(held));
      end
      if (prev_txv && !prev_rdy) begin
        check("tx_hold_valid", {63'd0, tx_valid}, 64'd1);
        check("tx_hold_data", 64'(tx_data), 64'(prev_txd));
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) check("tx_unexpected", {63'd0, tx_valid}, 64'd0);
        else check("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
      prev_txv  = tx_valid;
      prev_rdy  = tx_ready;
      prev_txd  = tx_data;
      prev_mreq = mem_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input bit accepted);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (accepted) mdl_byte(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic cmd_write(input logic [31:0] a, input logic [31:0] d,
                           input bit bad_csum, input int stall_idx);
    logic [7:0] bq[$];
    logic [7:0] x;
    bq.push_back(8'h57);
    for (int i = 0; i < 4; i++) bq.push_back(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) bq.push_back(d[8*i +: 8]);
`ifdef BOOT_CHECKSUM_EN
    x = '0;
    for (int i = 1; i <= 8; i++) x = x ^ bq[i];
    bq.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
    x = '0;
`endif
    for (int i = 0; i < bq.size(); i++) begin
      send_byte(bq[i], 1'b1);
      if (i == stall_idx) begin repeat (TMO - 1) @(posedge clk); #1; end
    end
  endtask

  task automatic cmd_read(input logic [31:0] a);
    send_byte(8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_tx.size() == 0) && (exp_mem.size() == 0) && !tx_valid && !mem_req;
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  task automatic wait_mem_req(input string name);
    for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
    check(name, {63'd0, mem_req}, 64'd1);
  endtask

  task automatic wait_tx(input string name);
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
    check(name, {63'd0, tx_valid}, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_reset", {63'd0, core_reset}, 64'd1);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_core_reset", {63'd0, core_reset}, 64'd1);
    check("idle_mem_req", {63'd0, mem_req}, 64'd0);
    check("idle_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("idle_overrun", {63'd0, overrun}, 64'd0);

    // write 0xDEADBEEF to byte address 0x10
    cmd_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, -1);
    wait_mem_req("wr_mem_req");
    check("wr_lit_we", {63'd0, mem_we}, 64'd1);
    check("wr_lit_addr", 64'(mem_addr), 64'h004);
    check("wr_lit_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    wait_tx("wr_ack_seen");
    check("wr_lit_ack", 64'(tx_data), 64'h06);
    wait_done("wr_done");

    // read back with a 5-cycle stall on the second byte
    cmd_read(32'h0000_0010);
    n = 0;
    while (n < 50 && !(tx_valid && tx_ready)) begin @(negedge clk); n++; end
    check("rd_lit_byte0", 64'(tx_data), 64'hEF);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rd_lit_hold", 64'(tx_data), 64'hBE);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_done("rd_done");

    // core control
    send_byte(8'h47, 1'b1);
    @(negedge clk);
    check("g_lit_core", {63'd0, core_reset}, 64'd0);
    check("g_lit_txv", {63'd0, tx_valid}, 64'd1);
    check("g_lit_ack", 64'(tx_data), 64'h06);
    wait_done("g_done");
    send_byte(8'h41, 1'b1);
    @(negedge clk);
    check("nak_lit", 64'(tx_data), 64'h15);
    check("nak_lit_core", {63'd0, core_reset}, 64'd0);
    wait_done("nak_done");
    send_byte(8'h48, 1'b1);
    @(negedge clk);
    check("h_lit_core", {63'd0, core_reset}, 64'd1);
    wait_done("h_done");

    // timeout on a partial write
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    mdl_timeout();
    n = 0;
    while (n < 40 && !tx_valid) begin @(negedge clk); n++; end
    check("tmo_lit_latency", 64'(n), 64'd17);
    check("tmo_lit_nak", 64'(tx_data), 64'h15);
    wait_done("tmo_done");
    cmd_write(32'h0000_0020, 32'h1234_5678, 1'b0, -1);
    wait_done("post_tmo_wr_done");

    // a byte arriving on the last timeout cycle is still accepted
    cmd_write(32'h0000_0030, 32'hA5A5_0F0F, 1'b0, 1);
    wait_mem_req("edge_mem_req");
    check("edge_lit_addr", 64'(mem_addr), 64'h00C);
    wait_done("edge_done");

    // overrun while the memory access is held off
    ack_delay = 6;
    cmd_write(32'h0000_0040, 32'hCAFE_F00D, 1'b0, -1);
    wait_mem_req("ovr_mem_req");
    send_byte(8'h55, 1'b0);
    @(negedge clk);
    check("ovr_lit", {63'd0, overrun}, 64'd1);
    wait_done("ovr_done");
    ack_delay = 3;

    // upper and lower address bits are ignored
    cmd_read(32'hFFFF_0043);
    wait_mem_req("rdhi_mem_req");
    check("rdhi_lit_addr", 64'(mem_addr), 64'h010);
    wait_done("rdhi_done");

`ifdef BOOT_CHECKSUM_EN
    cmd_write(32'h0000_0050, 32'h0BAD_C0DE, 1'b0, -1);
    wait_done("csum_ok_done");
    cmd_write(32'h0000_0054, 32'h1111_1111, 1'b1, -1);
    wait_tx("csum_bad_tx");
    check("csum_bad_lit_nak", 64'(tx_data), 64'h15);
    wait_done("csum_bad_done");
    cmd_read(32'h0000_0054);
    wait_done("csum_bad_rd_done");
`endif

    // async reset in the middle of a memory access
    send_byte(8'h47, 1'b1);
    wait_done("g2_done");
    ack_delay = 20;
    cmd_write(32'h0000_0060, 32'h5A5A_5A5A, 1'b0, -1);
    wait_mem_req("arst_mem_req");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", {63'd0, mem_req}, 64'd0);
    check("arst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("arst_core", {63'd0, core_reset}, 64'd1);
    check("arst_overrun", {63'd0, overrun}, 64'd0);
    mdl_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_delay = 3;
    repeat (3) @(posedge clk); #1;
    send_byte(8'h47, 1'b1);
    wait_done("post_rst_g_done");

    check("exp_tx_drained", 64'(exp_tx.size()), 64'd0);
    check("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
